// File: rtl/mem16_pkg.sv
// Shared types and constants for the 8-bit CPU to 16-bit memory bridge.
package mem16_pkg;

  localparam int ADDR_W  = 20;
  localparam int WORD_W  = 16;
  localparam int BYTE_W  = 8;
  localparam int WADDR_W = ADDR_W - 1;

  // Byte lane selects for the even and odd byte of a word
  localparam logic [1:0] BE_EVEN = 2'b01;
  localparam logic [1:0] BE_ODD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lane select for a byte address; bit 0 picks the odd byte
  function automatic logic [1:0] byte_en(input logic a0);
    return a0 ? BE_ODD : BE_EVEN;
  endfunction

endpackage

// File: rtl/mem16_bridge_if.sv
// CPU-side and memory-side signals of the bridge.
// slave: the bridge's view; master: the CPU/memory environment's view.
interface mem16_bridge_if;
  import mem16_pkg::*;

  logic [ADDR_W-1:0]  a;
  logic [BYTE_W-1:0]  o;
  logic               w;
  logic [BYTE_W-1:0]  i;
  logic               ce;
  logic [WADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0]  mem_wdata;
  logic [1:0]         mem_be;
  logic               mem_we;
  logic               mem_req;
  logic               mem_ack;
  logic [WORD_W-1:0]  mem_rdata;

  modport slave (
    input  a, o, w, mem_ack, mem_rdata,
    output i, ce, mem_addr, mem_wdata, mem_be, mem_we, mem_req
  );

  modport master (
    output a, o, w, mem_ack, mem_rdata,
    input  i, ce, mem_addr, mem_wdata, mem_be, mem_we, mem_req
  );

endinterface

// File: rtl/mem16_bridge.sv
// Bridges an 8-bit CPU bus (stalled via ce) onto a 16-bit request/ack memory.
// Optional one-word read buffer enabled by defining MEM16_BRIDGE_BUFFER_EN;
// without it every read goes to memory.
module mem16_bridge
  import mem16_pkg::*;
(
  input logic           clock,
  input logic           reset_n,
  mem16_bridge_if.slave bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [WADDR_W-1:0] r_mem_addr;
  logic [1:0]         r_mem_be;
  logic [WORD_W-1:0]  r_mem_wdata;
  logic [BYTE_W-1:0]  r_i;
  logic               w_ce;
  logic               w_hit;
  logic [BYTE_W-1:0]  w_hit_byte;
  logic [WADDR_W-1:0] w_word;
  logic               w_a0;
  logic               w_start;
  logic               w_ack;

  assign w_word  = bus.a[ADDR_W-1:1];
  assign w_a0    = bus.a[0];
  // Writes always go to memory; reads go only when the buffer cannot serve them
  assign w_start = (r_state == IDLE) && (bus.w || !w_hit);
  // Acks are only meaningful while a request is outstanding
  assign w_ack   = (r_state == BUSY) && bus.mem_ack;

`ifdef MEM16_BRIDGE_BUFFER_EN
  logic               r_buf_valid;
  logic [WADDR_W-1:0] r_buf_tag;
  logic [WORD_W-1:0]  r_buf_data;

  assign w_hit      = !bus.w && r_buf_valid && (r_buf_tag == w_word);
  assign w_hit_byte = w_a0 ? r_buf_data[WORD_W-1:BYTE_W] : r_buf_data[BYTE_W-1:0];

  // Fill on read completion; write-through patches only the addressed byte
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
    end else if (w_ack) begin
      if (!r_mem_we) begin
        r_buf_valid <= 1'b1;
        r_buf_tag   <= r_mem_addr;
        r_buf_data  <= bus.mem_rdata;
      end else if (r_buf_valid && (r_buf_tag == r_mem_addr)) begin
        if (r_mem_be[0]) r_buf_data[BYTE_W-1:0]      <= r_mem_wdata[BYTE_W-1:0];
        if (r_mem_be[1]) r_buf_data[WORD_W-1:BYTE_W] <= r_mem_wdata[WORD_W-1:BYTE_W];
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_byte = '0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = BUSY;
      BUSY:    if (bus.mem_ack) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // CPU clock-enable: zero-wait on a buffer hit, otherwise one cycle in DONE
  always_comb begin
    w_ce = 1'b0;
    case (r_state)
      IDLE:    w_ce = w_hit;
      DONE:    w_ce = 1'b1;
      default: w_ce = 1'b0;
    endcase
  end

  // Memory request: captured when leaving IDLE, held until the ack edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= BE_EVEN;
      r_mem_wdata <= '0;
    end else if (w_start) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= bus.w;
      r_mem_addr  <= w_word;
      r_mem_be    <= byte_en(w_a0);
      r_mem_wdata <= {bus.o, bus.o};
    end else if (w_ack) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
    end
  end

  // Read byte to CPU: updated only when a read completes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_i <= '0;
    end else if ((r_state == IDLE) && w_hit) begin
      r_i <= w_hit_byte;
    end else if (w_ack && !r_mem_we) begin
      r_i <= r_mem_be[1] ? bus.mem_rdata[WORD_W-1:BYTE_W] : bus.mem_rdata[BYTE_W-1:0];
    end
  end

  assign bus.i         = r_i;
  assign bus.ce        = w_ce;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
